// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit_pkg
// Purpose : Shared constants for the instruction fetch unit. Holds the jump
//           opcode, the position of the opcode field and the fetch FSM state
//           encodings.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package instr_fetch_unit_pkg;

   // Opcode field is the top OP_W bits of the instruction word
   localparam int         OP_W            = 4;
   localparam logic [3:0] JMP_OP_DEFAULT  = 4'hF;

   // Fetch FSM state encodings
   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t ST_SYNC     = 2'd0;
   localparam fetch_state_t ST_RUN      = 2'd1;
   localparam fetch_state_t ST_HOLD     = 2'd2;
   localparam fetch_state_t ST_REDIRECT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit_if
// Purpose : Bundles the PC/ROM side, decode-side handshake and execute
//           redirect signals of the fetch unit.
// Ports   : pc_addr/rom_data (PC -> fetch), branch/pcin (fetch -> PC),
//           instr_out/instr_pc/instr_valid/instr_ready (fetch <-> decode),
//           ex_redirect/ex_target (execute -> fetch).
//           master = fetch unit side, slave = surrounding system side.
// Rev     : 1.0  initial release
// ============================================================================
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] pc_addr;
   logic [DATA_W-1:0] rom_data;
   logic              branch;
   logic [ADDR_W-1:0] pcin;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              ex_redirect;
   logic [ADDR_W-1:0] ex_target;

   modport master (
      input  pc_addr, rom_data, instr_ready, ex_redirect, ex_target,
      output branch, pcin, instr_out, instr_pc, instr_valid
   );

   modport slave (
      output pc_addr, rom_data, instr_ready, ex_redirect, ex_target,
      input  branch, pcin, instr_out, instr_pc, instr_valid
   );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Purpose : Small circular buffer of fetched {pc, instruction} entries.
// Ports   : clk, rst (async active-low), push, pop, flush (clears all
//           entries, wins over push/pop), din, dout (head entry, 0 when
//           empty), count (registered occupancy).
// Rev     : 1.0  initial release
// ============================================================================
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 22
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // DEPTH is a power of two, so the pointers wrap by natural overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
      end
   end

   // Storage needs no reset: entries are only visible while count != 0
   always_ff @(posedge clk) begin
      if (push && !flush) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Purpose : Samples PC address and ROM word each cycle, keeps only the fetch
//           at the expected address, buffers it for decode and steers the PC
//           (branch/pcin) for start-up, jumps, execute redirects and
//           back-pressure holds.
// Ports   : clk, rst (async active-low), bus (instr_fetch_unit_if.master).
// Rev     : 1.0  initial release
// ============================================================================
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int               ADDR_W    = 6,
   parameter int               DATA_W    = 16,
   parameter int               DEPTH     = 2,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter logic [3:0]       JMP_OP    = JMP_OP_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_fetch_unit_if.master   bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int ENT_W = ADDR_W + DATA_W;

   fetch_state_t       r_state;
   logic [ADDR_W-1:0]  r_expected_pc;
   logic               r_branch;
   logic [ADDR_W-1:0]  r_pcin;

   logic [CNT_W-1:0]   w_count;
   logic [ENT_W-1:0]   w_dout;
   logic               w_valid;
   logic               w_full;
   logic               w_pop;
   logic               w_redirect;
   logic               w_accept;
   logic               w_is_jump;
   logic [ADDR_W-1:0]  w_target;

   assign w_valid    = (w_count != '0);
   assign w_full     = (w_count == CNT_W'(DEPTH));
   assign w_pop      = w_valid && bus.instr_ready;
   // Execute redirects are ignored until the PC has been synchronised
   assign w_redirect = bus.ex_redirect && (r_state != ST_SYNC);
   // A redirect flushes everything, so the sample of that cycle is dropped
   assign w_accept   = (r_state == ST_RUN) && (bus.pc_addr == r_expected_pc) &&
                       (!w_full || w_pop) && !w_redirect;
   assign w_is_jump  = (bus.rom_data[DATA_W-1 -: OP_W] == JMP_OP);
   assign w_target   = bus.rom_data[ADDR_W-1:0];

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_accept),
      .pop   (w_pop),
      .flush (w_redirect),
      .din   ({bus.pc_addr, bus.rom_data}),
      .dout  (w_dout),
      .count (w_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_SYNC;
         r_expected_pc <= RESET_VEC;
         r_branch      <= 1'b0;
         r_pcin        <= '0;
      end else if (w_redirect) begin
         r_state       <= ST_REDIRECT;
         r_expected_pc <= bus.ex_target;
         r_branch      <= 1'b1;
         r_pcin        <= bus.ex_target;
      end else begin
         case (r_state)
            ST_SYNC: begin
               r_state  <= ST_RUN;
               r_branch <= 1'b1;
               r_pcin   <= RESET_VEC;
            end
            ST_RUN: begin
               // Accept and HOLD entry are mutually exclusive: accept needs
               // room or a pop, HOLD entry needs full with no pop.
               if (w_accept) begin
                  r_expected_pc <= w_is_jump ? w_target : bus.pc_addr + ADDR_W'(1);
                  r_branch      <= w_is_jump;
                  if (w_is_jump) r_pcin <= w_target;
               end else if (w_full && !w_pop) begin
                  r_state  <= ST_HOLD;
                  r_branch <= 1'b1;
                  r_pcin   <= r_expected_pc;
               end else begin
                  r_branch <= 1'b0;
               end
            end
            ST_HOLD: begin
               // Keep reloading the PC; once a slot frees, stop reloading so
               // the PC's repeat of the load address is accepted next edge.
               if (w_pop) begin
                  r_state  <= ST_RUN;
                  r_branch <= 1'b0;
               end else begin
                  r_branch <= 1'b1;
                  r_pcin   <= r_expected_pc;
               end
            end
            ST_REDIRECT: begin
               r_state  <= ST_RUN;
               r_branch <= 1'b0;
            end
            default: begin
               r_state  <= ST_SYNC;
               r_branch <= 1'b0;
            end
         endcase
      end
   end

   assign bus.branch      = r_branch;
   assign bus.pcin        = r_pcin;
   assign bus.instr_valid = w_valid;
   assign bus.instr_out   = w_dout[DATA_W-1:0];
   assign bus.instr_pc    = w_dout[ENT_W-1 -: ADDR_W];

endmodule
`default_nettype wire
